// File: rtl/multi_pkg.sv
// Shared types for the multi shift-add multiplier controller: FSM states,
// the strobe bundle and the state-to-strobe decode.
package multi_pkg;

  localparam int MULTI_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    ADD,
    SHIFT,
    DONE
  } multi_state_t;

  typedef struct packed {
    logic clr;
    logic ld;
    logic ldp;
    logic shp;
    logic shb;
    logic busy;
    logic done;
  } multi_strobe_t;

  // Moore decode: strobes depend on the state alone.
  function automatic multi_strobe_t multi_decode(multi_state_t s);
    multi_strobe_t o;
    o      = '0;
    o.busy = (s != IDLE);
    case (s)
      CLEAR:   o.clr  = 1'b1;
      LOAD:    o.ld   = 1'b1;
      ADD:     o.ldp  = 1'b1;
      SHIFT: begin
        o.shp = 1'b1;
        o.shb = 1'b1;
      end
      DONE:    o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multi_iter_cnt.sv
// Iteration counter for multi_ctrl: loads WIDTH, decrements with saturation
// at zero, flags the final iteration with last.
module multi_iter_cnt #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CW'(WIDTH);
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign last = (cnt_reg == CW'(1));

endmodule

// File: rtl/multi_ctrl.sv
// Sequencer for the multi shift-add datapath: clear, load, WIDTH add/shift
// rounds, then a done pulse. Optional abort input with MULTI_CTRL_ABORT_EN.
module multi_ctrl
  import multi_pkg::*;
#(
  parameter int WIDTH = MULTI_WIDTH_DEF
) (
  input  logic clk,
  input  logic clr_n,
  input  logic start,
`ifdef MULTI_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic clr,
  output logic ld,
  output logic ldp,
  output logic shp,
  output logic shb,
  output logic busy,
  output logic done
);

  multi_state_t  state_reg;
  multi_state_t  state_next;
  multi_strobe_t strobe_reg;
  logic          last;
  logic          abort_hit;

`ifdef MULTI_CTRL_ABORT_EN
  assign abort_hit = abort && (state_reg != IDLE) && (state_reg != DONE);
`else
  assign abort_hit = 1'b0;
`endif

  multi_iter_cnt #(.WIDTH(WIDTH)) u_iter_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (abort_hit),
    .load  (state_reg == LOAD),
    .dec   (state_reg == SHIFT),
    .last  (last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = LOAD;
      LOAD:    state_next = ADD;
      ADD:     state_next = SHIFT;
      SHIFT:   state_next = last ? DONE : ADD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  // Strobes are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg  <= IDLE;
      strobe_reg <= '0;
    end else begin
      state_reg  <= state_next;
      strobe_reg <= multi_decode(state_next);
    end
  end

  assign clr  = strobe_reg.clr;
  assign ld   = strobe_reg.ld;
  assign ldp  = strobe_reg.ldp;
  assign shp  = strobe_reg.shp;
  assign shb  = strobe_reg.shb;
  assign busy = strobe_reg.busy;
  assign done = strobe_reg.done;

endmodule
